bus_tx_scheduler: RTL and testbench



---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_tx_scheduler_if.sv | 39 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/bus_tx_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_bus_tx_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus transmit scheduler.
package bus_pkg;

  localparam int unsigned PKT_W     = 79;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned SIZE_W    = 2;
  localparam int unsigned START_BIT = 78;
  localparam int unsigned STOP_BIT  = 0;
  localparam int unsigned CNT_W     = 7;

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    SHIFT,
    WAIT_ACK
  } state_e;

  // Per-requester fields latched at grant and replayed on every rebuild.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dst;
    logic [SIZE_W-1:0] size;
  } req_fields_t;

endpackage

// File: rtl/bus_tx_scheduler_if.sv
// Client / packet-builder / serial-line signal bundle of the transmit scheduler.
interface bus_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  import bus_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ADDR_W-1:0] req_dst;
  logic [NUM_REQ*SIZE_W-1:0] req_size;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        fail;
  logic                      mk_en;
  logic [DATA_W-1:0]         mk_data;
  logic [ADDR_W-1:0]         mk_sender;
  logic [ADDR_W-1:0]         mk_receiver;
  logic [SIZE_W-1:0]         mk_size;
  logic [PKT_W-1:0]          pkt_in;
  logic                      bus_tx;
  logic                      bus_busy;
  logic                      ack_valid;
  logic                      ack_ok;

  // Scheduler side.
  modport master (
    input  req, req_data, req_dst, req_size, pkt_in, ack_valid, ack_ok,
    output gnt, done, fail, mk_en, mk_data, mk_sender, mk_receiver, mk_size,
           bus_tx, bus_busy
  );

  // Clients, packet builder and receiver side.
  modport slave (
    output req, req_data, req_dst, req_size, pkt_in, ack_valid, ack_ok,
    input  gnt, done, fail, mk_en, mk_data, mk_sender, mk_receiver, mk_size,
           bus_tx, bus_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(N);

  logic          found_hi;
  logic          found_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Lowest request at/above the pointer wins; otherwise lowest request overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_lo = 1'b1;
        idx_lo   = IW'(i);
        if (IW'(i) >= ptr_i) begin
          found_hi = 1'b1;
          idx_hi   = IW'(i);
        end
      end
    end
    idx_o = found_hi ? idx_hi : idx_lo;
    gnt_o = found_lo ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/bus_tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter between NUM_REQ requesters.
// Optional BUS_RETRY_EN: retransmit on nack/timeout up to MAX_RETRY times.
module bus_tx_scheduler
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst,
  bus_tx_scheduler_if.master bus_if
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_BIT - STOP_BIT);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("bus_tx_scheduler: NUM_REQ must be in 2..16");
  end
  if (ACK_TIMEOUT < 1 || MAX_RETRY > 255) begin : g_bad_timing
    $error("bus_tx_scheduler: ACK_TIMEOUT must be >= 1 and MAX_RETRY <= 255");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] fail_q, fail_d;
  req_fields_t        fields_q, fields_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               bus_tx_q, bus_tx_d;
  logic               bus_busy_q, bus_busy_d;
  logic               mk_en_q, mk_en_d;

`ifdef BUS_RETRY_EN
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0] retry_q, retry_d;
`endif

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   next_ptr_c;
  req_fields_t        arb_fields_c;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (bus_if.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Pointer moves just past the requester that is finishing.
  assign next_ptr_c = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Select the winning requester's fields for latching.
  always_comb begin
    arb_fields_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_idx == IDX_W'(i)) begin
        arb_fields_c.data = bus_if.req_data[i*DATA_W +: DATA_W];
        arb_fields_c.dst  = bus_if.req_dst[i*ADDR_W +: ADDR_W];
        arb_fields_c.size = bus_if.req_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    fail_d    = '0;
    fields_d  = fields_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    bus_tx_d  = 1'b1;
`ifdef BUS_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (|bus_if.req) begin
          gnt_d    = arb_gnt;
          idx_d    = arb_idx;
          fields_d = arb_fields_c;
          state_d  = BUILD;
`ifdef BUS_RETRY_EN
          retry_d  = '0;
`endif
        end
      end

      BUILD: begin
        // Start bit goes out next cycle; the rest waits in the shift register.
        bus_tx_d  = bus_if.pkt_in[START_BIT];
        shift_d   = {bus_if.pkt_in[PKT_W-2:0], 1'b1};
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (bit_cnt_q == CNT_LAST) begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end else begin
          bus_tx_d  = shift_q[PKT_W-1];
          shift_d   = {shift_q[PKT_W-2:0], 1'b1};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      WAIT_ACK: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus_if.ack_valid && bus_if.ack_ok) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = next_ptr_c;
          state_d = IDLE;
        end else if (bus_if.ack_valid || (timer_q == TMR_W'(ACK_TIMEOUT - 1))) begin
`ifdef BUS_RETRY_EN
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = BUILD;
          end else
`endif
          begin
            fail_d  = gnt_q;
            gnt_d   = '0;
            ptr_d   = next_ptr_c;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    mk_en_d    = (state_d == BUILD);
    bus_busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      fail_q     <= '0;
      fields_q   <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      bus_tx_q   <= 1'b1;
      bus_busy_q <= 1'b0;
      mk_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      fields_q   <= fields_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      bus_tx_q   <= bus_tx_d;
      bus_busy_q <= bus_busy_d;
      mk_en_q    <= mk_en_d;
    end
  end

`ifdef BUS_RETRY_EN
  // Retransmission count for the current grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign bus_if.gnt         = gnt_q;
  assign bus_if.done        = done_q;
  assign bus_if.fail        = fail_q;
  assign bus_if.mk_en       = mk_en_q;
  assign bus_if.mk_data     = fields_q.data;
  assign bus_if.mk_sender   = ADDR_W'(idx_q);
  assign bus_if.mk_receiver = fields_q.dst;
  assign bus_if.mk_size     = fields_q.size;
  assign bus_if.bus_tx      = bus_tx_q;
  assign bus_if.bus_busy    = bus_busy_q;

endmodule

// File: tb/tb_bus_tx_scheduler.sv
// Directed self-checking bench for bus_tx_scheduler (default and BUS_RETRY_EN builds).
module tb_bus_tx_scheduler;
  import bus_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ACK_TO = 256;
  localparam int unsigned MAXR   = 3;
`ifdef BUS_RETRY_EN
  localparam int ATTEMPTS = int'(MAXR) + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] td   [NREQ];
  logic [ADDR_W-1:0] tdst [NREQ];
  logic [SIZE_W-1:0] tsz  [NREQ];

  bus_tx_scheduler_if #(.NUM_REQ(NREQ)) bif ();

  bus_tx_scheduler #(
    .NUM_REQ     (NREQ),
    .ACK_TIMEOUT (ACK_TO),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  // Packet builder model: start 0, fields, filler, stop 1.
  function automatic logic [PKT_W-1:0] build_pkt(input logic [3:0] snd, input logic [3:0] rcv,
                                                 input logic [1:0] sz, input logic [63:0] d);
    return {1'b0, snd, rcv, sz, d, 3'b101, 1'b1};
  endfunction

  assign bif.pkt_in = build_pkt(bif.mk_sender, bif.mk_receiver, bif.mk_size, bif.mk_data);

  always_comb begin
    bif.req_data = '0;
    bif.req_dst  = '0;
    bif.req_size = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      bif.req_data[j*DATA_W +: DATA_W] = td[j];
      bif.req_dst[j*ADDR_W +: ADDR_W]  = tdst[j];
      bif.req_size[j*SIZE_W +: SIZE_W] = tsz[j];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [1:0] i, input logic [63:0] d, input logic [3:0] dst,
                            input logic [1:0] sz);
    td[i]   = d;
    tdst[i] = dst;
    tsz[i]  = sz;
  endtask

  // Capture 79 serial bits MSB first; optionally strobe ack at one bit position.
  task automatic shift_capture(output logic [PKT_W-1:0] got, input int pulse_at);
    got = '0;
    for (int k = 0; k < int'(PKT_W); k++) begin
      bif.ack_valid = (k == pulse_at);
      bif.ack_ok    = (k == pulse_at);
      step();
      got = {got[PKT_W-2:0], bif.bus_tx};
    end
    bif.ack_valid = 1'b0;
    bif.ack_ok    = 1'b0;
  endtask

  initial begin
    logic [PKT_W-1:0] got;
    logic [3:0]       e;

    rst           = 1'b1;
    bif.req       = '0;
    bif.ack_valid = 1'b0;
    bif.ack_ok    = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      td[i]   = '0;
      tdst[i] = '0;
      tsz[i]  = '0;
    end
    repeat (3) step();

    // Reset state
    check("rst_gnt",    PKT_W'(bif.gnt),      PKT_W'(4'b0000));
    check("rst_done",   PKT_W'(bif.done),     PKT_W'(4'b0000));
    check("rst_fail",   PKT_W'(bif.fail),     PKT_W'(4'b0000));
    check("rst_bus_tx", PKT_W'(bif.bus_tx),   PKT_W'(1'b1));
    check("rst_busy",   PKT_W'(bif.bus_busy), PKT_W'(1'b0));
    check("rst_mk_en",  PKT_W'(bif.mk_en),    PKT_W'(1'b0));
    check("rst_mk_dat", PKT_W'(bif.mk_data),  PKT_W'(64'h0));
    rst = 1'b0;
    step();
    check("idle_busy", PKT_W'(bif.bus_busy), PKT_W'(1'b0));

    // Single transfer from requester 1
    set_fields(2'd1, 64'hDEADBEEF_01234567, 4'h9, 2'b11);
    bif.req = 4'b0010;
    step();
    bif.req = '0;
    check("s_gnt",    PKT_W'(bif.gnt),         PKT_W'(4'b0010));
    check("s_mk_en",  PKT_W'(bif.mk_en),       PKT_W'(1'b1));
    check("s_sender", PKT_W'(bif.mk_sender),   PKT_W'(4'h1));
    check("s_recv",   PKT_W'(bif.mk_receiver), PKT_W'(4'h9));
    check("s_size",   PKT_W'(bif.mk_size),     PKT_W'(2'b11));
    check("s_data",   PKT_W'(bif.mk_data),     PKT_W'(64'hDEADBEEF_01234567));
    check("s_busy",   PKT_W'(bif.bus_busy),    PKT_W'(1'b1));
    check("s_idle_tx", PKT_W'(bif.bus_tx),     PKT_W'(1'b1));
    shift_capture(got, -1);
    check("s_pkt",   got, build_pkt(4'h1, 4'h9, 2'b11, 64'hDEADBEEF_01234567));
    check("s_start", PKT_W'(got[PKT_W-1]), PKT_W'(1'b0));
    check("s_stop",  PKT_W'(bif.bus_tx),   PKT_W'(1'b1));
    check("s_mk_en_off", PKT_W'(bif.mk_en), PKT_W'(1'b0));
    step();
    check("s_wait_tx",   PKT_W'(bif.bus_tx),   PKT_W'(1'b1));
    check("s_wait_busy", PKT_W'(bif.bus_busy), PKT_W'(1'b1));
    check("s_wait_gnt",  PKT_W'(bif.gnt),      PKT_W'(4'b0010));
    repeat (9) step();
    check("s_no_done_early", PKT_W'(bif.done), PKT_W'(4'b0000));
    bif.ack_valid = 1'b1;
    bif.ack_ok    = 1'b1;
    step();
    bif.ack_valid = 1'b0;
    bif.ack_ok    = 1'b0;
    check("s_done",     PKT_W'(bif.done),     PKT_W'(4'b0010));
    check("s_done_gnt", PKT_W'(bif.gnt),      PKT_W'(4'b0000));
    check("s_done_fail", PKT_W'(bif.fail),    PKT_W'(4'b0000));
    check("s_done_busy", PKT_W'(bif.bus_busy), PKT_W'(1'b0));
    step();
    check("s_done_pulse", PKT_W'(bif.done), PKT_W'(4'b0000));

    // Round-robin with all requests held
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      set_fields(2'(i), 64'h1000_0000_0000_0000 + 64'(i), 4'(i + 4), 2'(i));
    end
    bif.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e = 4'b0001 << (n % 4);
      step();
      if (n == 4) bif.req = '0;
      check("rr_gnt",    PKT_W'(bif.gnt),       PKT_W'(e));
      check("rr_sender", PKT_W'(bif.mk_sender), PKT_W'(n % 4));
      repeat (80) begin
        step();
        check("rr_gnt_held", PKT_W'(bif.gnt), PKT_W'(e));
      end
      bif.ack_valid = 1'b1;
      bif.ack_ok    = 1'b1;
      step();
      bif.ack_valid = 1'b0;
      bif.ack_ok    = 1'b0;
      check("rr_done",     PKT_W'(bif.done), PKT_W'(e));
      check("rr_done_gnt", PKT_W'(bif.gnt),  PKT_W'(4'b0000));
    end

    // Nack on every attempt (retry count depends on build)
    set_fields(2'd2, 64'h0F1E2D3C_4B5A6978, 4'h3, 2'b01);
    bif.req = 4'b0100;
    step();
    bif.req = '0;
    check("n_gnt", PKT_W'(bif.gnt), PKT_W'(4'b0100));
    for (int a = 0; a < ATTEMPTS; a++) begin
      check("n_build", PKT_W'(bif.mk_en), PKT_W'(1'b1));
      shift_capture(got, -1);
      check("n_pkt", got, build_pkt(4'h2, 4'h3, 2'b01, 64'h0F1E2D3C_4B5A6978));
      step();
      check("n_wait_done", PKT_W'(bif.done), PKT_W'(4'b0000));
      bif.ack_valid = 1'b1;
      bif.ack_ok    = 1'b0;
      step();
      bif.ack_valid = 1'b0;
      if (a < ATTEMPTS - 1) begin
        check("n_retry_fail", PKT_W'(bif.fail), PKT_W'(4'b0000));
        check("n_retry_gnt",  PKT_W'(bif.gnt),  PKT_W'(4'b0100));
      end
    end
    check("n_fail",     PKT_W'(bif.fail), PKT_W'(4'b0100));
    check("n_fail_done", PKT_W'(bif.done), PKT_W'(4'b0000));
    check("n_fail_gnt", PKT_W'(bif.gnt),  PKT_W'(4'b0000));
    step();
    check("n_fail_pulse", PKT_W'(bif.fail), PKT_W'(4'b0000));

`ifndef BUS_RETRY_EN
    // Timeout, with a stray ack during SHIFT
    set_fields(2'd3, 64'h11223344_55667788, 4'hA, 2'b10);
    bif.req = 4'b1000;
    step();
    bif.req = '0;
    check("t_gnt", PKT_W'(bif.gnt), PKT_W'(4'b1000));
    shift_capture(got, 20);
    check("t_pkt",  got, build_pkt(4'h3, 4'hA, 2'b10, 64'h11223344_55667788));
    check("t_done", PKT_W'(bif.done), PKT_W'(4'b0000));
    step();
    repeat (int'(ACK_TO) - 1) step();
    check("t_no_fail_early", PKT_W'(bif.fail), PKT_W'(4'b0000));
    check("t_busy_early",    PKT_W'(bif.bus_busy), PKT_W'(1'b1));
    step();
    check("t_fail",      PKT_W'(bif.fail),     PKT_W'(4'b1000));
    check("t_fail_gnt",  PKT_W'(bif.gnt),      PKT_W'(4'b0000));
    check("t_fail_busy", PKT_W'(bif.bus_busy), PKT_W'(1'b0));
    check("t_fail_done", PKT_W'(bif.done),     PKT_W'(4'b0000));
`else
    // Bring the pointer back to 0 as the timeout case would have
    set_fields(2'd3, 64'h11223344_55667788, 4'hA, 2'b10);
    bif.req = 4'b1000;
    step();
    bif.req = '0;
    check("t_gnt", PKT_W'(bif.gnt), PKT_W'(4'b1000));
    repeat (80) step();
    bif.ack_valid = 1'b1;
    bif.ack_ok    = 1'b1;
    step();
    bif.ack_valid = 1'b0;
    check("t_done", PKT_W'(bif.done), PKT_W'(4'b1000));
`endif

    // Ack arriving on the last timeout cycle wins
    set_fields(2'd0, 64'hCAFEF00D_55AA55AA, 4'h5, 2'b00);
    bif.req = 4'b0001;
    step();
    bif.req = '0;
    check("a_gnt", PKT_W'(bif.gnt), PKT_W'(4'b0001));
    repeat (80) step();
    repeat (int'(ACK_TO) - 1) step();
    check("a_no_fail_early", PKT_W'(bif.fail), PKT_W'(4'b0000));
    bif.ack_valid = 1'b1;
    bif.ack_ok    = 1'b1;
    step();
    bif.ack_valid = 1'b0;
    bif.ack_ok    = 1'b0;
    check("a_done", PKT_W'(bif.done), PKT_W'(4'b0001));
    check("a_fail", PKT_W'(bif.fail), PKT_W'(4'b0000));
    step();
    check("a_fail_after",  PKT_W'(bif.fail),     PKT_W'(4'b0000));
    check("a_busy_after",  PKT_W'(bif.bus_busy), PKT_W'(1'b0));
    check("a_mk_en_after", PKT_W'(bif.mk_en),    PKT_W'(1'b0));

    // Reset in the middle of SHIFT
    set_fields(2'd2, 64'h01020304_05060708, 4'h7, 2'b10);
    bif.req = 4'b0100;
    step();
    bif.req = '0;
    check("r_gnt", PKT_W'(bif.gnt), PKT_W'(4'b0100));
    repeat (39) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_bus_tx", PKT_W'(bif.bus_tx),   PKT_W'(1'b1));
    check("r_gnt0",   PKT_W'(bif.gnt),      PKT_W'(4'b0000));
    check("r_done",   PKT_W'(bif.done),     PKT_W'(4'b0000));
    check("r_fail",   PKT_W'(bif.fail),     PKT_W'(4'b0000));
    check("r_busy",   PKT_W'(bif.bus_busy), PKT_W'(1'b0));
    set_fields(2'd0, 64'hA5A5A5A5_5A5A5A5A, 4'hC, 2'b01);
    bif.req = 4'b0001;
    step();
    bif.req = '0;
    check("r_new_gnt",    PKT_W'(bif.gnt),       PKT_W'(4'b0001));
    check("r_new_sender", PKT_W'(bif.mk_sender), PKT_W'(4'h0));
    check("r_new_data",   PKT_W'(bif.mk_data),   PKT_W'(64'hA5A5A5A5_5A5A5A5A));
    step();
    check("r_new_done", PKT_W'(bif.done), PKT_W'(4'b0000));
    check("r_new_fail", PKT_W'(bif.fail), PKT_W'(4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
